// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and sizing helpers for the store-and-forward AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } fifo_state_t;

    // One extra bit over the address width so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// {Tlast, Tdata} storage: synchronous write, combinational read.
module axis_pkt_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W:0]          rd_data
);

    logic [DATA_W:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward packet FIFO: releases a packet only after its Tlast beat is
// stored, and discards whole any packet longer than the buffer.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_ACCEPT | beats are written speculatively after the last committed packet
//   ST_DROP   | oversize packet rolled back; remaining beats sunk until Tlast
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        s_Tdata,
    input  logic                     s_Tvalid,
    input  logic                     s_Tlast,
    output logic                     s_Tready,
    output logic [DATA_W-1:0]        m_Tdata,
    output logic                     m_Tvalid,
    output logic                     m_Tlast,
    input  logic                     m_Tready,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     drop_pulse
);

    localparam int            PW       = ptr_width(DEPTH);
    localparam int            AW       = PW - 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] OPEN_MAX = PW'(DEPTH - 1);

    fifo_state_t     state;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_commit;
    logic [PW-1:0]   wr_spec;
    logic [PW-1:0]   pkt_cnt_q;
    logic [PW-1:0]   used;
    logic [PW-1:0]   open_cnt;
    logic [DATA_W:0] rd_entry;
    logic            in_acc;
    logic            rd_xfer;
    logic            rd_last;
    logic            overflow;
    logic            wr_en;
    logic            commit;

    assign used     = wr_spec - rd_ptr;
    assign open_cnt = wr_spec - wr_commit;

    assign s_Tready = (state == ST_DROP) || (used < DEPTH_P);
    assign in_acc   = s_Tvalid && s_Tready;

    // A non-final beat arriving when the open packet already fills all but one
    // entry can never fit: roll back instead of writing it.
    assign overflow = (state == ST_ACCEPT) && in_acc && !s_Tlast && (open_cnt == OPEN_MAX);
    assign wr_en    = (state == ST_ACCEPT) && in_acc && !overflow;
    assign commit   = wr_en && s_Tlast;

    assign m_Tvalid = (pkt_cnt_q != '0);
    assign m_Tdata  = m_Tvalid ? rd_entry[DATA_W-1:0] : '0;
    assign m_Tlast  = m_Tvalid && rd_entry[DATA_W];
    assign rd_xfer  = m_Tvalid && m_Tready;
    assign rd_last  = rd_xfer && rd_entry[DATA_W];

    assign pkt_count = pkt_cnt_q;

    axis_pkt_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_spec[AW-1:0]),
        .wr_data ({s_Tlast, s_Tdata}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ACCEPT;
            rd_ptr     <= '0;
            wr_commit  <= '0;
            wr_spec    <= '0;
            pkt_cnt_q  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;

            unique case (state)
                ST_ACCEPT: begin
                    if (overflow) begin
                        wr_spec <= wr_commit;
                        state   <= ST_DROP;
                    end else if (wr_en) begin
                        wr_spec <= wr_spec + 1'b1;
                        if (s_Tlast) begin
                            wr_commit <= wr_spec + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (in_acc && s_Tlast) begin
                        state      <= ST_ACCEPT;
                        drop_pulse <= 1'b1;
                    end
                end
                default: state <= ST_ACCEPT;
            endcase

            if (rd_xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // Commit and Tlast read-out in the same cycle cancel out.
            if (commit && !rd_last) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end else if (rd_last && !commit) begin
                pkt_cnt_q <= pkt_cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Randomized bench for axis_pkt_fifo against a packet-level queue model.
module tb_axis_pkt_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic                   clk;
    logic                   reset;
    logic [DATA_W-1:0]      s_Tdata;
    logic                   s_Tvalid;
    logic                   s_Tlast;
    logic                   s_Tready;
    logic [DATA_W-1:0]      m_Tdata;
    logic                   m_Tvalid;
    logic                   m_Tlast;
    logic                   m_Tready;
    logic [$clog2(DEPTH):0] pkt_count;
    logic                   drop_pulse;

    axis_pkt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_Tdata    (s_Tdata),
        .s_Tvalid   (s_Tvalid),
        .s_Tlast    (s_Tlast),
        .s_Tready   (s_Tready),
        .m_Tdata    (m_Tdata),
        .m_Tvalid   (m_Tvalid),
        .m_Tlast    (m_Tlast),
        .m_Tready   (m_Tready),
        .pkt_count  (pkt_count),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Stimulus source and reference model state.
    beat_t in_q[$];
    beat_t st_q[$];
    beat_t op_q[$];
    int    mdl_npk    = 0;
    bit    mdl_drop   = 0;
    bit    mdl_dpulse = 0;
    int    mr_mode    = 0;
    int    gap_pct    = 0;
    int    drops_seen = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_pkt(input int len, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = 8'(base + i);
            b.last = (i == len - 1);
            in_q.push_back(b);
        end
    endtask

    task automatic push_rand_pkt(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = 8'($urandom_range(255));
            b.last = (i == len - 1);
            in_q.push_back(b);
        end
    endtask

    task automatic cycle();
        logic  exp_rdy;
        logic  exp_mv;
        logic  acc;
        logic  rd;
        beat_t hd;
        beat_t b;
        @(negedge clk);
        exp_rdy = mdl_drop || ((st_q.size() + op_q.size()) < DEPTH);
        exp_mv  = (mdl_npk != 0);
        hd      = (exp_mv && st_q.size() != 0) ? st_q[0] : '0;
        chk("s_Tready",   32'(s_Tready),   32'(exp_rdy));
        chk("m_Tvalid",   32'(m_Tvalid),   32'(exp_mv));
        chk("m_Tdata",    32'(m_Tdata),    32'(hd.data));
        chk("m_Tlast",    32'(m_Tlast),    32'(hd.last));
        chk("pkt_count",  32'(pkt_count), mdl_npk);
        chk("drop_pulse", 32'(drop_pulse), 32'(mdl_dpulse));
        if (drop_pulse) drops_seen++;

        b        = (in_q.size() != 0) ? in_q[0] : '0;
        s_Tvalid = (in_q.size() != 0) && ($urandom_range(99) >= gap_pct);
        s_Tdata  = b.data;
        s_Tlast  = b.last;
        m_Tready = (mr_mode == 1) ? 1'b1 : (mr_mode == 2) ? 1'($urandom_range(1)) : 1'b0;

        acc        = s_Tvalid && exp_rdy;
        rd         = exp_mv && m_Tready;
        mdl_dpulse = 0;
        if (rd) begin
            hd = st_q.pop_front();
            if (hd.last) mdl_npk--;
        end
        if (acc) begin
            void'(in_q.pop_front());
            if (mdl_drop) begin
                if (b.last) begin
                    mdl_drop   = 0;
                    mdl_dpulse = 1;
                end
            end else if (b.last) begin
                op_q.push_back(b);
                foreach (op_q[i]) st_q.push_back(op_q[i]);
                op_q.delete();
                mdl_npk++;
            end else if (op_q.size() == DEPTH - 1) begin
                op_q.delete();
                mdl_drop = 1;
            end else begin
                op_q.push_back(b);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        s_Tvalid = 1'b0;
        m_Tready = 1'b0;
        #1;
        in_q.delete();
        st_q.delete();
        op_q.delete();
        mdl_npk    = 0;
        mdl_drop   = 0;
        mdl_dpulse = 0;
        chk("rst_m_Tvalid",   32'(m_Tvalid),   0);
        chk("rst_s_Tready",   32'(s_Tready),   1);
        chk("rst_pkt_count",  32'(pkt_count),  0);
        chk("rst_m_Tdata",    32'(m_Tdata),    0);
        chk("rst_m_Tlast",    32'(m_Tlast),    0);
        chk("rst_drop_pulse", 32'(drop_pulse), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int d0;
        reset    = 1'b0;
        s_Tvalid = 1'b0;
        s_Tlast  = 1'b0;
        s_Tdata  = '0;
        m_Tready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Single 4-beat packet, downstream always ready.
        mr_mode = 1;
        push_pkt(4, 8'h11);
        run(10);

        // Exactly-DEPTH packet held, then drained.
        mr_mode = 0;
        push_pkt(16, 8'h30);
        run(20);
        mr_mode = 1;
        run(20);

        // Oversize packet into empty FIFO, then a short packet.
        d0 = drops_seen;
        push_pkt(20, 8'h60);
        push_pkt(2, 8'hA0);
        run(30);
        chk("oversize_drop_cnt", drops_seen - d0, 1);

        // Tlast of held packet leaves in the cycle the next packet's Tlast arrives.
        mr_mode = 0;
        push_pkt(3, 8'hC0);
        run(5);
        mr_mode = 1;
        push_pkt(3, 8'hD0);
        run(10);

        // Oversize packet while a committed packet drains.
        mr_mode = 0;
        push_pkt(3, 8'hE0);
        run(4);
        mr_mode = 1;
        d0 = drops_seen;
        push_pkt(20, 8'h80);
        run(30);
        chk("drain_drop_cnt", drops_seen - d0, 1);

        // Reset with one committed packet and two open beats.
        mr_mode = 0;
        push_pkt(2, 8'h40);
        in_q.push_back('{last: 1'b0, data: 8'h44});
        in_q.push_back('{last: 1'b0, data: 8'h45});
        run(5);
        chk("pre_rst_pkt_count", 32'(pkt_count), 1);
        do_reset();
        mr_mode = 1;
        push_pkt(1, 8'h5A);
        run(5);

        // Random traffic with backpressure, gaps and occasional oversize packets.
        gap_pct = 20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) mr_mode = $urandom_range(2);
            if (in_q.size() < 4 && $urandom_range(3) == 0)
                push_rand_pkt($urandom_range(1, 22));
            if (c == 1500) do_reset();
            cycle();
        end
        mr_mode = 1;
        gap_pct = 0;
        run(60);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
